// File: rtl/flag_sequencer_if.sv
// Control/status bundle between the acquisition controller (master)
// and the flag sequencer (slave).
interface flag_sequencer_if #(
    parameter int CNT_W   = 4,
    parameter int N_FLAGS = 3
);
    logic                       Start;
    logic                       Clear;
    logic                       EN;
    logic                       Wrap;
    logic [CNT_W-1:0]           Term;
    logic [N_FLAGS*CNT_W-1:0]   Taps;
    logic [CNT_W-1:0]           Count;
    logic [N_FLAGS-1:0]         Flags;
    logic [N_FLAGS-1:0]         Flag_Pulse;
    logic                       Busy;
    logic                       Done;
    logic                       Wrap_Pulse;

    modport master (
        output Start, Clear, EN, Wrap, Term, Taps,
        input  Count, Flags, Flag_Pulse, Busy, Done, Wrap_Pulse
    );

    modport slave (
        input  Start, Clear, EN, Wrap, Term, Taps,
        output Count, Flags, Flag_Pulse, Busy, Done, Wrap_Pulse
    );
endinterface

// File: rtl/flag_sequencer.sv
// Enable-stepped phase counter (saturate or wrap at Term) driving N_FLAGS
// programmable tap flags plus Busy/Done status for the correlation datapath.
module flag_sequencer #(
    parameter int CNT_W   = 4,
    parameter int N_FLAGS = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    flag_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [N_FLAGS-1:0]   r_flag_pulse;
    logic [N_FLAGS-1:0]   w_flag_pulse_nxt;
    logic [N_FLAGS-1:0]   w_flags;
    logic                 r_wrap_pulse;
    logic                 w_wrap_nxt;
    logic                 w_step;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_flag_pulse <= '0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_flag_pulse <= w_flag_pulse_nxt;
            r_wrap_pulse <= w_wrap_nxt;
        end
    end

    // NOTE: every signal gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_wrap_nxt       = 1'b0;
        w_step           = 1'b0;
        w_flag_pulse_nxt = '0;

        if (bus.Clear) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else if (bus.Start) begin
            w_state_nxt = S_RUN;
            w_count_nxt = '0;
            w_step      = 1'b1;
        end else if (r_state == S_RUN && bus.EN) begin
            // ">=" keeps the counter bounded when Term is lowered mid-run.
            if (r_count >= bus.Term) begin
                if (bus.Wrap) begin
                    w_count_nxt = '0;
                    w_wrap_nxt  = 1'b1;
                    w_step      = 1'b1;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end else begin
                w_count_nxt = r_count + CNT_W'(1);
                w_step      = 1'b1;
            end
        end

        // Pulses only on a real step or restart, never on a hold.
        for (int i = 0; i < N_FLAGS; i++) begin
            w_flag_pulse_nxt[i] = w_step && (w_count_nxt == bus.Taps[i*CNT_W +: CNT_W]);
        end
    end

    always_comb begin
        w_flags = '0;
        for (int i = 0; i < N_FLAGS; i++) begin
            w_flags[i] = (r_state != S_IDLE) && (r_count == bus.Taps[i*CNT_W +: CNT_W]);
        end
    end

    assign bus.Count      = r_count;
    assign bus.Flags      = w_flags;
    assign bus.Flag_Pulse = r_flag_pulse;
    assign bus.Busy       = (r_state == S_RUN);
    assign bus.Done       = (r_state == S_DONE);
    assign bus.Wrap_Pulse = r_wrap_pulse;
endmodule

// File: tb/tb_flag_sequencer.sv
// Self-checking bench for flag_sequencer: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_flag_sequencer;
    localparam int CNT_W   = 4;
    localparam int N_FLAGS = 3;
    localparam int VW      = CNT_W + 2*N_FLAGS + 3;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    flag_sequencer_if #(.CNT_W(CNT_W), .N_FLAGS(N_FLAGS)) bus ();

    flag_sequencer #(.CNT_W(CNT_W), .N_FLAGS(N_FLAGS)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = idle, 1 = running, 2 = finished.
    int                 m_phase = 0;
    int                 m_count = 0;
    logic [N_FLAGS-1:0] m_fp    = '0;
    logic               m_wp    = 1'b0;

    function automatic int tap(int i);
        return int'(bus.Taps[i*CNT_W +: CNT_W]);
    endfunction

    task automatic model_step();
        logic [N_FLAGS-1:0] fp;
        logic wp;
        logic step;
        fp = '0; wp = 1'b0; step = 1'b0;
        if (Reset) begin
            m_phase = 0; m_count = 0;
        end else if (bus.Clear) begin
            m_phase = 0; m_count = 0;
        end else if (bus.Start) begin
            m_phase = 1; m_count = 0; step = 1'b1;
        end else if (m_phase == 1 && bus.EN) begin
            if (m_count >= int'(bus.Term)) begin
                if (bus.Wrap) begin
                    m_count = 0; wp = 1'b1; step = 1'b1;
                end else begin
                    m_phase = 2;
                end
            end else begin
                m_count = m_count + 1; step = 1'b1;
            end
        end
        if (step) for (int i = 0; i < N_FLAGS; i++) fp[i] = (m_count == tap(i));
        m_fp = fp;
        m_wp = wp;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [N_FLAGS-1:0] f;
        f = '0;
        for (int i = 0; i < N_FLAGS; i++) f[i] = (m_phase != 0) && (m_count == tap(i));
        return {CNT_W'(m_count), f, m_fp, (m_phase == 1), (m_phase == 2), m_wp};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.Count, bus.Flags, bus.Flag_Pulse, bus.Busy, bus.Done, bus.Wrap_Pulse};
    endfunction

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic st, input logic cl, input logic en);
        bus.Start = st;
        bus.Clear = cl;
        bus.EN    = en;
    endtask

    task automatic test_reset();
        bus.Term = 4'd9; bus.Wrap = 1'b0; bus.Taps = {4'd0, 4'd0, 4'd0};
        drive(1'b1, 1'b0, 1'b1);
        Reset = 1'b1;
        tick();
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", obs_vec(), {VW{1'b0}});
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_vec());
        end
        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_saturate();
        int sat_cnt  [8] = '{0, 1, 2, 3, 4, 5, 5, 5};
        int sat_done [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
        int pc [N_FLAGS];
        bus.Term = 4'd5; bus.Wrap = 1'b0; bus.Taps = {4'd4, 4'd2, 4'd1};
        drive(1'b0, 1'b1, 1'b0); tick();
        for (int i = 0; i < N_FLAGS; i++) pc[i] = 0;
        for (int k = 0; k < 8; k++) begin
            drive(k == 0, 1'b0, k != 0);
            tick();
            checks++;
            if ({bus.Count, bus.Done} !== {CNT_W'(sat_cnt[k]), 1'(sat_done[k])}) begin
                errors++;
                $display("FAIL sat_seq[%0d]: got count=%0d done=%0d expected count=%0d done=%0d",
                         k, bus.Count, bus.Done, sat_cnt[k], sat_done[k]);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL sat_model[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
            end
            for (int i = 0; i < N_FLAGS; i++) pc[i] += int'(bus.Flag_Pulse[i]);
        end
        for (int i = 0; i < N_FLAGS; i++) begin
            checks++;
            if (pc[i] !== 1) begin
                errors++; $display("FAIL sat_pulse_count[%0d]: got %0d expected 1", i, pc[i]);
            end
        end
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++; $display("FAIL sat_busy_after_done: got %0d expected 0", bus.Busy);
        end
    endtask

    task automatic test_wrap();
        int wrap_cnt [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        int wp = 0;
        int dn = 0;
        bus.Term = 4'd3; bus.Wrap = 1'b1; bus.Taps = {4'd3, 4'd0, 4'd2};
        drive(1'b0, 1'b1, 1'b0); tick();
        for (int k = 0; k < 10; k++) begin
            drive(k == 0, 1'b0, k != 0);
            tick();
            checks++;
            if (bus.Count !== CNT_W'(wrap_cnt[k])) begin
                errors++; $display("FAIL wrap_seq[%0d]: got %0d expected %0d", k, bus.Count, wrap_cnt[k]);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL wrap_model[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
            end
            wp += int'(bus.Wrap_Pulse);
            dn += int'(bus.Done);
        end
        checks++;
        if (wp !== 2 || dn !== 0) begin
            errors++; $display("FAIL wrap_pulses: got wraps=%0d done=%0d expected wraps=2 done=0", wp, dn);
        end
    endtask

    task automatic test_en_hold();
        int en_pat [4] = '{1, 0, 0, 1};
        int exp_fl [4] = '{1, 1, 1, 0};
        int exp_fp [4] = '{1, 0, 0, 0};
        bus.Term = 4'd9; bus.Wrap = 1'b0; bus.Taps = {4'd7, 4'd7, 4'd1};
        drive(1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0); tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'(en_pat[k]));
            tick();
            checks++;
            if ({bus.Flags[0], bus.Flag_Pulse[0]} !== {1'(exp_fl[k]), 1'(exp_fp[k])}) begin
                errors++;
                $display("FAIL en_hold[%0d]: got flag=%0d pulse=%0d expected flag=%0d pulse=%0d",
                         k, bus.Flags[0], bus.Flag_Pulse[0], exp_fl[k], exp_fp[k]);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL en_hold_model[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_restart();
        bus.Term = 4'd9; bus.Wrap = 1'b0; bus.Taps = {4'd0, 4'd5, 4'd3};
        drive(1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1); tick(); tick(); tick();
        drive(1'b1, 1'b0, 1'b1); tick();
        checks++;
        if ({bus.Count, bus.Flags[2], bus.Flag_Pulse[2], bus.Busy} !== {CNT_W'(0), 3'b111}) begin
            errors++;
            $display("FAIL restart: got count=%0d flag2=%0d pulse2=%0d busy=%0d expected 0 1 1 1",
                     bus.Count, bus.Flags[2], bus.Flag_Pulse[2], bus.Busy);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL restart_model[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clear_start();
        bus.Term = 4'd9; bus.Wrap = 1'b0; bus.Taps = {4'd0, 4'd2, 4'd0};
        drive(1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1); tick(); tick();
        drive(1'b1, 1'b1, 1'b1); tick();
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL clear_start: got %h expected %h", obs_vec(), {VW{1'b0}});
        end
    endtask

    task automatic test_boundaries();
        int wp = 0;
        logic seen = 1'b0;
        // Term = 0, saturate
        bus.Term = 4'd0; bus.Wrap = 1'b0; bus.Taps = {4'd1, 4'd2, 4'd0};
        drive(1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1); tick();
        checks++;
        if ({bus.Busy, bus.Done, bus.Count} !== {2'b01, CNT_W'(0)}) begin
            errors++; $display("FAIL term0_sat: got busy=%0d done=%0d count=%0d expected 0 1 0",
                               bus.Busy, bus.Done, bus.Count);
        end
        // Term = 0, wrap
        bus.Wrap = 1'b1;
        drive(1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0); tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1); tick();
            wp += int'(bus.Wrap_Pulse);
        end
        checks++;
        if (wp !== 4) begin
            errors++; $display("FAIL term0_wrap: got %0d wrap pulses expected 4", wp);
        end
        // Tap beyond Term
        bus.Term = 4'd2; bus.Taps = {4'd7, 4'd1, 4'd2};
        drive(1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0); tick();
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b0, 1'b1); tick();
            seen = seen | bus.Flags[2] | bus.Flag_Pulse[2];
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL tap_above_term: got %0d expected 0", seen);
        end
        // Term all ones, wrap, checked against the model
        bus.Term = 4'hF; bus.Taps = {4'hF, 4'h0, 4'h8};
        drive(1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0); tick();
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b0, 1'b1); tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL term_max[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        // Reset mid-run
        Reset = 1'b1; tick();
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset_mid_run: got %h expected %h", obs_vec(), {VW{1'b0}});
        end
        Reset = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            Reset     = ($urandom_range(0, 199) == 0);
            bus.Start = ($urandom_range(0, 99) < 5);
            bus.Clear = ($urandom_range(0, 99) < 3);
            bus.EN    = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 59) == 0) bus.Wrap = 1'($urandom);
            if ($urandom_range(0, 49) == 0) bus.Term = CNT_W'($urandom);
            if ($urandom_range(0, 39) == 0) bus.Taps = (N_FLAGS*CNT_W)'($urandom);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
            end
        end
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        bus.Start = 1'b0; bus.Clear = 1'b0; bus.EN = 1'b0; bus.Wrap = 1'b0;
        bus.Term = '0; bus.Taps = '0;
        test_reset();
        test_saturate();
        test_wrap();
        test_en_hold();
        test_restart();
        test_clear_start();
        test_boundaries();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
